// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage -- instruction-fetch stage of the five-stage LoongArch pipeline.
//
// Takes a PC, and possibly an instruction that pre-IF has already buffered,
// from pre-IF. If no instruction came with the PC, the stage waits for the
// in-order instruction-SRAM response. It holds the instruction until decode
// accepts it. A response owed to a flushed or branch-cancelled fetch is
// dropped. Misaligned PCs are flagged as ADEF toward decode.
//
// Ports
//   clk, resetn        clock; synchronous active-low reset
//   pfs_to_fs_valid    pre-IF offers a fetch
//   pfs_to_fs_bus      [64] inst_ok, [63:32] inst, [31:0] pc
//   fs_allowin         IF can accept a fetch this cycle
//   fs_block           IF holds its instruction; the current SRAM response
//                      belongs to pre-IF
//   inst_sram_data_ok  SRAM response strobe (in order)
//   inst_sram_rdata    SRAM response data
//   ds_allowin         decode can accept
//   fs_to_ds_valid     instruction offered to decode
//   fs_to_ds_bus       [64] adef, [63:32] inst, [31:0] pc
//   br_cancel          taken branch in decode; kills IF contents
//   flush              writeback exception / ertn; kills IF contents
// ----------------------------------------------------------------------------
module if_stage (
   input  logic        clk,
   input  logic        resetn,
   input  logic        pfs_to_fs_valid,
   input  logic [64:0] pfs_to_fs_bus,
   output logic        fs_allowin,
   output logic        fs_block,
   input  logic        inst_sram_data_ok,
   input  logic [31:0] inst_sram_rdata,
   input  logic        ds_allowin,
   output logic        fs_to_ds_valid,
   output logic [64:0] fs_to_ds_bus,
   input  logic        br_cancel,
   input  logic        flush
);

   logic        fs_valid;
   logic        fs_inst_ok;
   logic        discard;
   logic [31:0] fs_pc;
   logic [31:0] fs_inst;

   logic        take;
   logic        fs_ready_go;
   logic        kill;
   logic        leave;
   logic        load;

   // A response is ours only when nothing stale is still owed and we are
   // actually waiting for one.
   assign take        = inst_sram_data_ok & ~discard & fs_valid & ~fs_inst_ok;
   assign fs_ready_go = fs_inst_ok | take;
   assign fs_allowin  = ~fs_valid | (fs_ready_go & ds_allowin);
   assign kill        = (flush | br_cancel) & fs_valid;
   assign leave       = fs_valid & fs_ready_go & ds_allowin;
   // During a kill, pre-IF presents the redirected PC in the same cycle.
   // Accept that PC even though the killed fetch would otherwise hold
   // fs_allowin low.
   assign load        = pfs_to_fs_valid & (fs_allowin | kill);

   assign fs_to_ds_valid = fs_valid & fs_ready_go & ~flush & ~br_cancel;
   assign fs_block       = fs_valid & fs_inst_ok;
   // Zero-cycle bypass: forward rdata directly in the cycle it arrives.
   assign fs_to_ds_bus   = {(fs_pc[1:0] != 2'b00),
                            (fs_inst_ok ? fs_inst : inst_sram_rdata),
                            fs_pc};

   always_ff @(posedge clk) begin
      if (!resetn) begin
         fs_valid   <= 1'b0;
         fs_inst_ok <= 1'b0;
         discard    <= 1'b0;
         fs_pc      <= 32'h0;
         fs_inst    <= 32'h0;
      end else begin
         if (load) begin
            fs_valid   <= 1'b1;
            fs_pc      <= pfs_to_fs_bus[31:0];
            fs_inst    <= pfs_to_fs_bus[63:32];
            fs_inst_ok <= pfs_to_fs_bus[64];
         end else if (kill || leave) begin
            fs_valid   <= 1'b0;
            fs_inst_ok <= 1'b0;
         end else if (take) begin
            // take without leave means decode is stalled; hold the data.
            fs_inst    <= inst_sram_rdata;
            fs_inst_ok <= 1'b1;
         end

         // A killed fetch whose response has not arrived still owes one
         // response. The set branch takes priority over the clear branch.
         // If an older stale response lands in the same cycle as a kill,
         // the newly killed request is still outstanding, so discard
         // stays set.
         if (kill && !fs_inst_ok && !take)
            discard <= 1'b1;
         else if (discard && inst_sram_data_ok)
            discard <= 1'b0;
      end
   end

endmodule
